vector_alu_iter: RTL
====================

VECTOR_ALU_ITER -- requirements
Module: vector_alu_iter

Interface
REQ-001 Parameter LANES, default 4, vector lane count; power of two, 2..16.
REQ-002 Parameter WIDTH, default 32, lane/scalar width in bits; two's-complement integer.
REQ-003 Derived IW = clog2(LANES), index width per lane.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operation request.
REQ-007 in_ready  out  1  block accepts request.
REQ-008 op  in  4  opcode (REQ-014).
REQ-009 imm  in  LANES*IW  per-lane index field, lane i at bits [i*IW +: IW].
REQ-010 v1, v2  in  LANES*WIDTH each  vector operands, lane i at [i*WIDTH +: WIDTH].
REQ-011 r1, r2  in  WIDTH each  scalar operands.
REQ-012 out_valid / out_ready  out / in  1 each  result handshake.
REQ-013 vout  out  LANES*WIDTH  vector result; rout  out  WIDTH  scalar result.

Function
REQ-014 Opcodes: 0 VADD, 1 VSUB, 2 VMULT, 3 VDOT, 4 VDOTA, 5 VINDX, 6 VREDUCE, 7 VSPLAT, 8 VSWIZZLE, 9 VSADD, 10 VSSUB, 11 VSMULT, 12 VSMA, 13 VCOMPSEL, 14 VMAX, 15 VMIN.
REQ-015 Per lane i: VADD v1+v2; VSUB v1-v2; VMULT low WIDTH bits of v1*v2; VSPLAT r1; VSWIZZLE v1[imm lane i]; VSADD v1+r1; VSSUB v1-r1; VSMULT v1*r1; VSMA v1*r1+v2; VCOMPSEL (v1>v2)?r1:r2; VMAX/VMIN signed max/min of v1,v2.
REQ-016 Scalar ops: VDOT sum of v1[i]*v2[i]; VDOTA same plus r2; VINDX v1[imm lane 0]; VREDUCE sum of v1 lanes.
REQ-017 All arithmetic wraps modulo 2^WIDTH unless REQ-030 applies; comparisons signed.
REQ-018 FSM states IDLE, EXEC, ACC, DONE.
REQ-019 in_ready = 1 only in IDLE; accept occurs on in_valid && in_ready at clk edge; all operands captured at accept.
REQ-020 IDLE -> EXEC on accept for lane ops and VINDX; IDLE -> ACC for VDOT, VDOTA, VREDUCE.
REQ-021 EXEC -> DONE after exactly one cycle; out_valid asserted 2 cycles after accept edge.
REQ-022 ACC: accumulator starts at 0 (VDOTA: r2), adds one lane term per cycle lane 0..LANES-1 via lane counter; ACC -> DONE after LANES cycles; out_valid LANES+1 cycles after accept.
REQ-023 DONE: out_valid = 1; vout/rout stable until out_ready; DONE -> IDLE on out_ready.
REQ-024 Scalar ops leave vout unchanged; vector ops leave rout unchanged.
REQ-025 in_valid while not in IDLE is ignored (no capture, no side effect).
REQ-026 out_valid and in_ready never both 1 in same cycle.

Reset
REQ-027 rst asserted: state IDLE, vout = 0, rout = 0, out_valid = 0, accumulator and lane counter 0, regardless of clock.
REQ-028 Reset during EXEC, ACC or DONE aborts the operation; no result is ever presented for it.
REQ-029 First cycle after rst release: in_ready = 1.

Configuration
REQ-030 Macro VALU_SATURATE_EN defined: VADD, VSUB, VSADD, VSSUB saturate per lane to signed range [-2^(WIDTH-1), 2^(WIDTH-1)-1]; undefined: those ops wrap per REQ-017. Multiply and reduction ops always wrap.

Verification (LANES=4, WIDTH=32)
REQ-031 VADD v1={1,2,3,4}, v2={10,20,30,40}, out_ready=1 -> out_valid 2 cycles after accept, vout={11,22,33,44}, one-cycle pulse.
REQ-032 VDOTA v1={1,2,3,4}, v2={2,2,2,2}, r2=5 -> out_valid 5 cycles after accept, rout=25.
REQ-033 VMAX v1={-1,5,0,7}, v2={3,-2,0,9}, out_ready held 0 for 3 cycles -> vout={3,5,0,9} stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-034 VADD lane0 0x7FFFFFFF+1 -> 0x80000000 without VALU_SATURATE_EN, 0x7FFFFFFF with it.
REQ-035 VREDUCE v1={1,1,1,1}, rst pulsed on second ACC cycle -> out_valid stays 0, rout=0, in_ready=1 after release; next VREDUCE returns 4.
REQ-036 VSWIZZLE imm={3,2,1,0} (lane0 index 3), v1={0xA,0xB,0xC,0xD} -> vout={0xD,0xC,0xB,0xA}.

Source files
------------

// File: rtl/vector_alu_iter.sv
// Iterative vector ALU: lane ops finish in one EXEC cycle, reductions walk
// the lanes one per ACC cycle. Define VALU_SATURATE_EN for saturating add/sub.
module vector_alu_iter #(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic [LANES*$clog2(LANES)-1:0] imm,
    input  logic [LANES*WIDTH-1:0]   v1,
    input  logic [LANES*WIDTH-1:0]   v2,
    input  logic [WIDTH-1:0]         r1,
    input  logic [WIDTH-1:0]         r2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   vout,
    output logic [WIDTH-1:0]         rout
);

    localparam int IW = $clog2(LANES);

    typedef enum logic [3:0] {
        VADD, VSUB, VMULT, VDOT, VDOTA, VINDX, VREDUCE, VSPLAT,
        VSWIZZLE, VSADD, VSSUB, VSMULT, VSMA, VCOMPSEL, VMAX, VMIN
    } op_e;

    typedef enum logic [1:0] {IDLE, EXEC, ACC, DONE} state_e;

    state_e                   state;
    op_e                      op_q;
    logic [LANES*IW-1:0]      imm_q;
    logic [LANES*WIDTH-1:0]   v1_q;
    logic [LANES*WIDTH-1:0]   v2_q;
    logic [WIDTH-1:0]         r1_q;
    logic [WIDTH-1:0]         r2_q;
    logic [WIDTH-1:0]         acc;
    logic [IW-1:0]            cnt;
    logic [LANES*WIDTH-1:0]   lane_res;
    logic [WIDTH-1:0]         term;
    logic [WIDTH-1:0]         indx_res;

    function automatic logic [WIDTH-1:0] lane_of(
        input logic [LANES*WIDTH-1:0] vec,
        input int idx
    );
        return vec[idx*WIDTH +: WIDTH];
    endfunction

    // Add or subtract with a guard bit; clamps on signed overflow when enabled.
    function automatic logic [WIDTH-1:0] addsub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sub
    );
        logic [WIDTH:0] s;
        s = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
                : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
`ifdef VALU_SATURATE_EN
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] lane_calc(
        input op_e              o,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] sw,
        input logic [WIDTH-1:0] s1,
        input logic [WIDTH-1:0] s2
    );
        logic [WIDTH-1:0] res;
        case (o)
            VADD:     res = addsub(a, b, 1'b0);
            VSUB:     res = addsub(a, b, 1'b1);
            VMULT:    res = a * b;
            VSPLAT:   res = s1;
            VSWIZZLE: res = sw;
            VSADD:    res = addsub(a, s1, 1'b0);
            VSSUB:    res = addsub(a, s1, 1'b1);
            VSMULT:   res = a * s1;
            VSMA:     res = a * s1 + b;
            VCOMPSEL: res = ($signed(a) > $signed(b)) ? s1 : s2;
            VMAX:     res = ($signed(a) > $signed(b)) ? a : b;
            VMIN:     res = ($signed(a) < $signed(b)) ? a : b;
            default:  res = '0;
        endcase
        return res;
    endfunction

    // Per-lane results of the captured operation, consumed in EXEC.
    always_comb begin
        lane_res = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_res[i*WIDTH +: WIDTH] = lane_calc(
                op_q,
                lane_of(v1_q, i),
                lane_of(v2_q, i),
                lane_of(v1_q, int'(imm_q[i*IW +: IW])),
                r1_q,
                r2_q);
        end
    end

    // Current reduction term and the indexed scalar pick.
    always_comb begin
        term = '0;
        if (op_q == VREDUCE)
            term = lane_of(v1_q, int'(cnt));
        else
            term = lane_of(v1_q, int'(cnt)) * lane_of(v2_q, int'(cnt));
        indx_res = lane_of(v1_q, int'(imm_q[IW-1:0]));
    end

    // Control FSM with operand capture and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            vout      <= '0;
            rout      <= '0;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= VADD;
            imm_q     <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_e'(op);
                        imm_q    <= imm;
                        v1_q     <= v1;
                        v2_q     <= v2;
                        r1_q     <= r1;
                        r2_q     <= r2;
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        if (op == VDOT || op == VDOTA || op == VREDUCE) begin
                            acc   <= (op == VDOTA) ? r2 : '0;
                            state <= ACC;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (op_q == VINDX)
                        rout <= indx_res;
                    else
                        vout <= lane_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                ACC: begin
                    acc <= acc + term;
                    cnt <= cnt + 1'b1;
                    if (cnt == IW'(LANES - 1)) begin
                        rout      <= acc + term;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
